// File: rtl/mem_arbiter.sv
// Arbitrates the ICache/DCache requests onto one memory port and routes completion tags back to their owner.
// Optional build macro: MEM_ARB_STATS_EN enables the grant/conflict statistics counters.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = 16,
  parameter int CNT_W        = 32,
  parameter int XLEN         = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       Ictrl2mem_command,
  input  logic [XLEN-1:0]  Ictrl2mem_addr,
  input  logic [1:0]       Dctrl2mem_command,
  input  logic [XLEN-1:0]  Dctrl2mem_addr,
  input  logic [63:0]      Dctrl2mem_data,
  input  logic             rob_near_empty,
  input  logic [3:0]       mem2proc_response,
  input  logic [3:0]       mem2proc_tag,
  output logic [1:0]       proc2mem_command,
  output logic [XLEN-1:0]  proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  output logic [3:0]       Imem2Ictrl_response,
  output logic [3:0]       Imem2Ictrl_tag,
  output logic [3:0]       Dmem2Dctrl_response,
  output logic [3:0]       Dmem2Dctrl_tag,
  output logic             reject_I_req,
  output logic             reject_D_req,
  output logic             tag_error,
  output logic [CNT_W-1:0] i_grant_cnt,
  output logic [CNT_W-1:0] d_grant_cnt,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam int         RW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [RW-1:0] LIMIT  = RW'(STARVE_LIMIT);

  logic          i_req, d_req, grant_i, grant_d, starve_i, starve_d;
  logic [RW-1:0] i_rej_q, i_rej_d, d_rej_q, d_rej_d;
  logic [NUM_TAGS-1:0] valid_q, valid_d, owner_q, owner_d; // owner bit: 1 = DCache
  logic          tag_hit, alloc, tag_error_q, tag_error_d;

  assign i_req    = (Ictrl2mem_command != BUS_NONE);
  assign d_req    = (Dctrl2mem_command != BUS_NONE);
  assign starve_i = (i_rej_q >= LIMIT);
  assign starve_d = (d_rej_q >= LIMIT);
  assign grant_d  = d_req && (!i_req || starve_d || (!starve_i && !rob_near_empty));
  assign grant_i  = i_req && !grant_d;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (grant_i) begin
      proc2mem_command = Ictrl2mem_command;
      proc2mem_addr    = Ictrl2mem_addr;
    end else if (grant_d) begin
      proc2mem_command = Dctrl2mem_command;
      proc2mem_addr    = Dctrl2mem_addr;
      if (Dctrl2mem_command == BUS_STORE) proc2mem_data = Dctrl2mem_data;
    end
  end

  assign Imem2Ictrl_response = grant_i ? mem2proc_response : 4'd0;
  assign Dmem2Dctrl_response = grant_d ? mem2proc_response : 4'd0;
  assign reject_I_req        = i_req && !grant_i;
  assign reject_D_req        = d_req && !grant_d;

  assign tag_hit        = (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];
  assign Imem2Ictrl_tag = (tag_hit && !owner_q[mem2proc_tag]) ? mem2proc_tag : 4'd0;
  assign Dmem2Dctrl_tag = (tag_hit &&  owner_q[mem2proc_tag]) ? mem2proc_tag : 4'd0;
  assign alloc          = (proc2mem_command == BUS_LOAD) && (mem2proc_response != 4'd0);
  assign tag_error_d    = tag_error_q || ((mem2proc_tag != 4'd0) && !valid_q[mem2proc_tag]);
  assign tag_error      = tag_error_q;

  // Reject counters: loser saturates upward, winner clears, idle side holds.
  always_comb begin
    i_rej_d = i_rej_q;
    d_rej_d = d_rej_q;
    if (i_req) i_rej_d = grant_i ? '0 : (starve_i ? LIMIT : i_rej_q + 1'b1);
    if (d_req) d_rej_d = grant_d ? '0 : (starve_d ? LIMIT : d_rej_q + 1'b1);
  end

  // Allocation is applied after the clear so a same-tag reallocation survives.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    if (tag_hit) valid_d[mem2proc_tag] = 1'b0;
    if (alloc) begin
      valid_d[mem2proc_response] = 1'b1;
      owner_d[mem2proc_response] = grant_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i_rej_q     <= '0;
      d_rej_q     <= '0;
      valid_q     <= '0;
      owner_q     <= '0;
      tag_error_q <= 1'b0;
    end else begin
      i_rej_q     <= i_rej_d;
      d_rej_q     <= d_rej_d;
      valid_q     <= valid_d;
      owner_q     <= owner_d;
      tag_error_q <= tag_error_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [CNT_W-1:0] i_grant_q, d_grant_q, conflict_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      i_grant_q  <= '0;
      d_grant_q  <= '0;
      conflict_q <= '0;
    end else begin
      if (grant_i)         i_grant_q  <= i_grant_q + 1'b1;
      if (grant_d)         d_grant_q  <= d_grant_q + 1'b1;
      if (i_req && d_req)  conflict_q <= conflict_q + 1'b1;
    end
  end

  assign i_grant_cnt  = i_grant_q;
  assign d_grant_cnt  = d_grant_q;
  assign conflict_cnt = conflict_q;
`else
  assign i_grant_cnt  = '0;
  assign d_grant_cnt  = '0;
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table-driven cycle vectors plus hand sequences for tag/reset/stats corners.
module tb_mem_arbiter;
  localparam logic [1:0] N = 2'd0, L = 2'd1, S = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  Ictrl2mem_command, Dctrl2mem_command, proc2mem_command;
  logic [31:0] Ictrl2mem_addr, Dctrl2mem_addr, proc2mem_addr;
  logic [63:0] Dctrl2mem_data, proc2mem_data;
  logic        rob_near_empty;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [3:0]  Imem2Ictrl_response, Imem2Ictrl_tag, Dmem2Dctrl_response, Dmem2Dctrl_tag;
  logic        reject_I_req, reject_D_req, tag_error;
  logic [31:0] i_grant_cnt, d_grant_cnt, conflict_cnt;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .Ictrl2mem_command(Ictrl2mem_command), .Ictrl2mem_addr(Ictrl2mem_addr),
    .Dctrl2mem_command(Dctrl2mem_command), .Dctrl2mem_addr(Dctrl2mem_addr),
    .Dctrl2mem_data(Dctrl2mem_data), .rob_near_empty(rob_near_empty),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .Imem2Ictrl_response(Imem2Ictrl_response), .Imem2Ictrl_tag(Imem2Ictrl_tag),
    .Dmem2Dctrl_response(Dmem2Dctrl_response), .Dmem2Dctrl_tag(Dmem2Dctrl_tag),
    .reject_I_req(reject_I_req), .reject_D_req(reject_D_req), .tag_error(tag_error),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  ic;  logic [31:0] ia;
    logic [1:0]  dc;  logic [31:0] da;  logic [63:0] dd;
    logic        rob; logic [3:0]  resp; logic [3:0] tag;
    logic [1:0]  e_cmd; logic [31:0] e_addr; logic [63:0] e_data;
    logic [3:0]  e_ir, e_dr, e_it, e_dt;
    logic        e_rji, e_rjd, e_te;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] ic, input logic [31:0] ia, input logic [1:0] dc,
                     input logic [31:0] da, input logic [63:0] dd, input logic rob,
                     input logic [3:0] resp, input logic [3:0] tag,
                     input logic [1:0] e_cmd, input logic [31:0] e_addr, input logic [63:0] e_data,
                     input logic [3:0] e_ir, input logic [3:0] e_dr, input logic e_rji,
                     input logic e_rjd, input logic [3:0] e_it, input logic [3:0] e_dt,
                     input logic e_te);
    vec_t v;
    v.ic = ic; v.ia = ia; v.dc = dc; v.da = da; v.dd = dd; v.rob = rob;
    v.resp = resp; v.tag = tag; v.e_cmd = e_cmd; v.e_addr = e_addr; v.e_data = e_data;
    v.e_ir = e_ir; v.e_dr = e_dr; v.e_rji = e_rji; v.e_rjd = e_rjd;
    v.e_it = e_it; v.e_dt = e_dt; v.e_te = e_te;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [1:0] ic, input logic [31:0] ia, input logic [1:0] dc,
                       input logic [31:0] da, input logic [63:0] dd, input logic rob,
                       input logic [3:0] resp, input logic [3:0] tag);
    Ictrl2mem_command = ic; Ictrl2mem_addr = ia;
    Dctrl2mem_command = dc; Dctrl2mem_addr = da; Dctrl2mem_data = dd;
    rob_near_empty = rob; mem2proc_response = resp; mem2proc_tag = tag;
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled at the falling edge.
  task automatic settle();
    #4;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(N, 0, N, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(N, 0, N, 0, 0, 0, 0, 0);

    // Sequence from reset: isolation, conflict policy, starvation, tag routing, store, unknown tags.
    add(N,0,    N,0,      0,0,0,0,  N,0,      0,          0,0,0,0,0,0,0); // 0 idle
    add(N,0,    L,'h1008, 0,0,3,0,  L,'h1008, 0,          0,3,0,0,0,0,0); // 1 D alone, tag 3
    add(N,0,    N,0,      0,0,0,3,  N,0,      0,          0,0,0,0,0,3,0); // 2 tag 3 to D
    add(L,0,    L,'h2000, 0,0,0,0,  L,'h2000, 0,          0,0,1,0,0,0,0); // 3 conflict, D
    add(L,0,    L,'h2000, 0,1,0,0,  L,0,      0,          0,0,0,1,0,0,0); // 4 rob -> I
    add(N,0,    L,'h2000, 0,1,0,0,  L,'h2000, 0,          0,0,0,0,0,0,0); // 5 clear D count
    add(L,0,    L,'h2000, 0,1,0,0,  L,0,      0,          0,0,0,1,0,0,0); // 6 I
    add(L,0,    L,'h2000, 0,1,0,0,  L,0,      0,          0,0,0,1,0,0,0); // 7 I
    add(L,0,    L,'h2000, 0,1,0,0,  L,0,      0,          0,0,0,1,0,0,0); // 8 I
    add(L,0,    L,'h2000, 0,1,0,0,  L,0,      0,          0,0,0,1,0,0,0); // 9 I
    add(L,0,    L,'h2000, 0,1,0,0,  L,'h2000, 0,          0,0,1,0,0,0,0); // 10 D starved
    add(L,0,    L,'h2000, 0,1,0,0,  L,0,      0,          0,0,0,1,0,0,0); // 11 I
    add(L,'h40, N,0,      0,0,5,0,  L,'h40,   0,          5,0,0,0,0,0,0); // 12 I tag 5
    add(N,0,    S,'h3000, 'hDEADBEEF,0,7,0, S,'h3000,'hDEADBEEF, 0,7,0,0,0,0,0); // 13 store
    add(N,0,    L,'h3008, 0,0,6,0,  L,'h3008, 0,          0,6,0,0,0,0,0); // 14 D tag 6
    add(N,0,    N,0,      0,0,0,6,  N,0,      0,          0,0,0,0,0,6,0); // 15 tag 6 to D
    add(N,0,    N,0,      0,0,0,5,  N,0,      0,          0,0,0,0,5,0,0); // 16 tag 5 to I
    add(N,0,    N,0,      0,0,0,9,  N,0,      0,          0,0,0,0,0,0,0); // 17 unissued tag 9
    add(N,0,    N,0,      0,0,0,0,  N,0,      0,          0,0,0,0,0,0,1); // 18 error latched
    add(N,0,    N,0,      0,0,0,7,  N,0,      0,          0,0,0,0,0,0,1); // 19 store tag 7
    add(N,0,    N,0,      0,0,0,0,  N,0,      0,          0,0,0,0,0,0,1); // 20 sticky

    do_reset();
    settle();
    chk("rst tag_error", tag_error, 0);
    chk("rst i_grant", i_grant_cnt, 0);
    chk("rst d_grant", d_grant_cnt, 0);
    chk("rst conflict", conflict_cnt, 0);
    next_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i].ic, vecs[i].ia, vecs[i].dc, vecs[i].da, vecs[i].dd,
            vecs[i].rob, vecs[i].resp, vecs[i].tag);
      settle();
      chk($sformatf("v%0d cmd", i),   proc2mem_command,    vecs[i].e_cmd);
      chk($sformatf("v%0d addr", i),  proc2mem_addr,       vecs[i].e_addr);
      chk($sformatf("v%0d data", i),  proc2mem_data,       vecs[i].e_data);
      chk($sformatf("v%0d iresp", i), Imem2Ictrl_response, vecs[i].e_ir);
      chk($sformatf("v%0d dresp", i), Dmem2Dctrl_response, vecs[i].e_dr);
      chk($sformatf("v%0d rej_i", i), reject_I_req,        vecs[i].e_rji);
      chk($sformatf("v%0d rej_d", i), reject_D_req,        vecs[i].e_rjd);
      chk($sformatf("v%0d itag", i),  Imem2Ictrl_tag,      vecs[i].e_it);
      chk($sformatf("v%0d dtag", i),  Dmem2Dctrl_tag,      vecs[i].e_dt);
      chk($sformatf("v%0d tag_err", i), tag_error,         vecs[i].e_te);
      next_cycle();
    end

    // Tag 2 completes for I while being reallocated to D in the same cycle.
    do_reset();
    drive(L, 'h80, N, 0, 0, 0, 2, 0);
    settle();
    chk("realloc first iresp", Imem2Ictrl_response, 2);
    next_cycle();
    drive(N, 0, L, 'h88, 0, 0, 2, 2);
    settle();
    chk("realloc old owner itag", Imem2Ictrl_tag, 2);
    chk("realloc old dtag", Dmem2Dctrl_tag, 0);
    chk("realloc dresp", Dmem2Dctrl_response, 2);
    next_cycle();
    drive(N, 0, N, 0, 0, 0, 0, 2);
    settle();
    chk("realloc new owner dtag", Dmem2Dctrl_tag, 2);
    chk("realloc new itag", Imem2Ictrl_tag, 0);
    chk("realloc no error", tag_error, 0);
    next_cycle();

    // Reset while tags 1 (I) and 2 (D) are outstanding.
    do_reset();
    drive(L, 'h100, N, 0, 0, 0, 1, 0);
    next_cycle();
    drive(N, 0, L, 'h108, 0, 0, 2, 0);
    next_cycle();
    reset = 1'b1;
    drive(N, 0, L, 'h500, 0, 0, 0, 0);
    settle();
    chk("in reset cmd", proc2mem_command, L);
    chk("in reset addr", proc2mem_addr, 'h500);
    next_cycle();
    reset = 1'b0;
    drive(N, 0, N, 0, 0, 0, 0, 1);
    settle();
    chk("post rst tag1 i", Imem2Ictrl_tag, 0);
    chk("post rst err clear", tag_error, 0);
    next_cycle();
    drive(N, 0, N, 0, 0, 0, 0, 2);
    settle();
    chk("post rst tag2 d", Dmem2Dctrl_tag, 0);
    chk("post rst tag_error", tag_error, 1);
    next_cycle();

    // Statistics: three conflict cycles then two I-only cycles.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(L, 0, L, 'h2000, 0, 0, 0, 0);
      next_cycle();
    end
    for (int k = 0; k < 2; k++) begin
      drive(L, 0, N, 0, 0, 0, 0, 0);
      next_cycle();
    end
    drive(N, 0, N, 0, 0, 0, 0, 0);
    settle();
`ifdef MEM_ARB_STATS_EN
    chk("stats conflict", conflict_cnt, 3);
    chk("stats grants", 64'(i_grant_cnt) + 64'(d_grant_cnt), 5);
    chk("stats d_grant", d_grant_cnt, 3);
`else
    chk("stats conflict off", conflict_cnt, 0);
    chk("stats i_grant off", i_grant_cnt, 0);
    chk("stats d_grant off", d_grant_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
